// File: rtl/axi_sfr_regfile_if.sv
// AXI4-Lite bus bundle between the SPI-to-AXI bridge (master) and the SFR bank (slave).
interface axi_sfr_regfile_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_sfr_regfile.sv
// AXI4-Lite slave bank of DATA_W-bit SFRs at byte address 4*index, with a write-commit strobe port.
// Define AXI_SFR_WSTRB_EN to honour wstrb byte lanes; otherwise every in-range write updates all bits.
module axi_sfr_regfile #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16,  // must stay below 32
  parameter int IDX_W  = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi_sfr_regfile_if.slave      s_axi,
  output logic                  wr_strobe,
  output logic [IDX_W-1:0]      wr_index,
  output logic [DATA_W-1:0]     wr_value
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         SEL_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    WR_COLLECT,
    WR_RESP
  } wr_state_t;

  function automatic logic addr_hit(input logic [31:0] addr);
    logic [31:0] upper;
    logic [31:0] idx;
    upper = addr >> (IDX_W + 2);
    idx   = 32'(addr[IDX_W+1:2]);
    return (upper == '0) && (idx < 32'(DEPTH));
  endfunction

  logic [DATA_W-1:0] sfr [DEPTH];

  // Write channel state
  wr_state_t         wr_state;
  wr_state_t         wr_state_next;
  logic              aw_full;
  logic              w_full;
  logic [31:0]       aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [3:0]        w_strb;
  logic [1:0]        bresp_q;
  logic              commit;
  logic              b_done;
  logic              wr_hit;
  logic              wr_update;
  logic [SEL_W-1:0]  wr_sel;
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_new;

  // Read channel state
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              ar_hit;
  logic [SEL_W-1:0]  ar_sel;

  logic              unused_bits;

  assign s_axi.awready = ~aw_full;
  assign s_axi.wready  = ~w_full;
  assign s_axi.bvalid  = (wr_state == WR_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = ~rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign b_done = (wr_state == WR_RESP) && s_axi.bready;

  // AW and W are captured independently; both latches drop only on the B handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (b_done) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (s_axi.awvalid && !aw_full) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi.awaddr;
      end
      if (s_axi.wvalid && !w_full) begin
        w_full <= 1'b1;
        w_data <= s_axi.wdata[DATA_W-1:0];
        w_strb <= s_axi.wstrb;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) wr_state <= WR_COLLECT;
    else        wr_state <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state;
    commit        = 1'b0;
    case (wr_state)
      WR_COLLECT: begin
        if (aw_full && w_full) begin
          commit        = 1'b1;
          wr_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.bready) wr_state_next = WR_COLLECT;
      end
      default: wr_state_next = WR_COLLECT;
    endcase
  end

`ifdef AXI_SFR_WSTRB_EN
  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < DATA_W; b++) bit_mask[b] = w_strb[2'(b / 8)];
  end
`else
  assign bit_mask = '1;
`endif

  assign wr_sel    = aw_addr[SEL_W+1:2];
  assign wr_hit    = addr_hit(aw_addr);
  assign wr_old    = wr_hit ? sfr[wr_sel] : '0;
  assign wr_new    = (wr_old & ~bit_mask) | (w_data & bit_mask);
  assign wr_update = commit && wr_hit && (|bit_mask);

  assign wr_strobe = wr_update;
  assign wr_index  = aw_addr[IDX_W+1:2];
  assign wr_value  = wr_new;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)      bresp_q <= RESP_OKAY;
    else if (commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
  end

  // NOTE: the SFRs must read 0 after reset, so the bank is a reset flop array, not an inferred RAM.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) sfr[i] <= '0;
    end else if (wr_update) begin
      sfr[wr_sel] <= wr_new;
    end
  end

  assign ar_sel = s_axi.araddr[SEL_W+1:2];
  assign ar_hit = addr_hit(s_axi.araddr);

  // NOTE: non-blocking update of sfr means a read accepted in the commit cycle samples the old value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (rvalid_q) begin
      if (s_axi.rready) rvalid_q <= 1'b0;
    end else if (s_axi.arvalid) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_hit ? 32'(sfr[ar_sel]) : '0;
      rresp_q  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.wdata[31:DATA_W], w_strb};

endmodule
